pc_fetch: RTL and testbench

//  Program-counter and instruction-fetch stage. Owns the PC register and applies the
//  ctl pcsel code to select the next PC. Fetches each instruction over a req/ack

---
 rtl/pc_fetch_pkg.sv | 25 ++
 rtl/pc_fetch_if.sv | 24 ++
 rtl/pc_next_mux.sv | 36 +++
 rtl/pc_fetch.sv | 94 +++++++++
 tb/tb_pc_fetch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the PC / instruction-fetch stage.
// Optional feature macro: PC_IRQ_SYNC_EN (see pc_fetch.sv).
package pc_fetch_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

    localparam logic [2:0] PCSEL_PC4   = 3'd0;
    localparam logic [2:0] PCSEL_BR    = 3'd1;
    localparam logic [2:0] PCSEL_JT    = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP = 3'd3;
    localparam logic [2:0] PCSEL_XADR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] p);
        return {1'b0, p[30:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory req/ack port between the fetch stage and memory.
// The fetch stage is the master.
interface pc_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch stage.
// Supervisor bit pc[31] is preserved by sequential/branch targets.
module pc_next_mux
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic [2:0]  pcsel,
    input  logic [15:0] lit,
    input  logic [31:0] jt,
    output logic [31:0] next_pc
);

    logic [30:0] seq;
    logic [30:0] off;
    logic        unused_bits;

    assign seq = pc[30:0] + 31'd4;
    assign off = {{13{lit[15]}}, lit, 2'b00};
    assign unused_bits = ^{pc[1:0], jt[1:0]};

    always_comb begin
        next_pc = ILLOP_VEC;
        case (pcsel)
            PCSEL_PC4:  next_pc = {pc[31], seq};
            PCSEL_BR:   next_pc = {pc[31], seq + off};
            // a jump may drop supervisor mode but never enter it
            PCSEL_JT:   next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
            PCSEL_XADR: next_pc = XADR_VEC;
            default:    next_pc = ILLOP_VEC;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter, fetch FSM, instruction register and interrupt latch.
// Define PC_IRQ_SYNC_EN to pass irq_in through a 2-flop synchronizer.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [2:0]   pcsel,
    input  logic [15:0]  lit,
    input  logic [31:0]  jt,
    input  logic         pc_en,
    input  logic         irq_in,
    pc_fetch_if.master   imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic         irq
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  next_pc;
    logic         take;
    logic         irq_s;
    logic         irq_lat;

    pc_next_mux #(
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_mux (
        .pc      (pc),
        .pcsel   (pcsel),
        .lit     (lit),
        .jt      (jt),
        .next_pc (next_pc)
    );

    assign take = (state == S_VALID) & pc_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem.ack) state_nxt = S_VALID;
            S_VALID: if (pc_en) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= RESET_VEC;
            instr <= 32'h0;
        end else begin
            if (take) pc <= next_pc;
            if (state == S_REQ && imem.ack) instr <= imem.rdata;
        end
    end

`ifdef PC_IRQ_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b00;
        else          sync <= {sync[0], irq_in};
    end
    assign irq_s = sync[1];
`else
    assign irq_s = irq_in;
`endif

    // a fresh interrupt beats the clear from an XADR retire
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          irq_lat <= 1'b0;
        else if (irq_s)                        irq_lat <= 1'b1;
        else if (take && pcsel == PCSEL_XADR)  irq_lat <= 1'b0;
    end

    assign imem.req    = (state == S_REQ);
    assign imem.addr   = word_addr(pc);
    assign instr_valid = (state == S_VALID);
    assign pc_plus4    = {pc[31], pc[30:0] + 31'd4};
    assign irq         = irq_lat & instr_valid & ~pc[31];

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized self-checking bench for pc_fetch against a cycle-level model.
// Build with or without PC_IRQ_SYNC_EN; the model follows the same macro.
module tb_pc_fetch;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] XV = 32'h8000_0008;

    logic        clk;
    logic        reset_n;
    logic [2:0]  pcsel;
    logic [15:0] lit;
    logic [31:0] jt;
    logic        pc_en;
    logic        irq_in;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        irq;

    pc_fetch_if imem ();

    pc_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pcsel       (pcsel),
        .lit         (lit),
        .jt          (jt),
        .pc_en       (pc_en),
        .irq_in      (irq_in),
        .imem        (imem.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_req;
    bit          m_idle;
    bit          m_pend;
    bit          irq_hist[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p,
                                               input logic [2:0] s,
                                               input logic [15:0] l,
                                               input logic [31:0] j);
        logic [31:0] off;
        logic [31:0] sb;
        off = {{14{l[15]}}, l, 2'b00};
        sb  = p & 32'h8000_0000;
        case (s)
            3'd0:    return sb | ((p + 32'd4) & 32'h7FFF_FFFF);
            3'd1:    return sb | ((p + 32'd4 + off) & 32'h7FFF_FFFF);
            3'd2:    return (p & j & 32'h8000_0000) | (j & 32'h7FFF_FFFC);
            3'd4:    return XV;
            default: return IV;
        endcase
    endfunction

    task automatic model_reset();
        m_pc    = RV;
        m_instr = 32'h0;
        m_valid = 0;
        m_req   = 0;
        m_idle  = 1;
        m_pend  = 0;
        irq_hist.delete();
    endtask

    task automatic compare_all();
        check("req", 32'(imem.req), 32'(m_req));
        check("addr", imem.addr, {1'b0, m_pc[30:2], 2'b00});
        check("valid", 32'(instr_valid), 32'(m_valid));
        check("instr", instr, m_instr);
        check("pc", pc, m_pc);
        check("pc4", pc_plus4, {m_pc[31], m_pc[30:0] + 31'd4});
        check("irq", 32'(irq), 32'(m_pend & m_valid & ~m_pc[31]));
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cycle(input bit en, input logic [2:0] sel,
                         input logic [15:0] l, input logic [31:0] j,
                         input bit ack, input logic [31:0] rd, input bit iv);
        bit smp;
        bit tk;
        pc_en = en; pcsel = sel; lit = l; jt = j;
        imem.ack = ack; imem.rdata = rd; irq_in = iv;
        @(posedge clk);
        irq_hist.push_back(iv);
`ifdef PC_IRQ_SYNC_EN
        smp = (irq_hist.size() > 2) ? irq_hist[irq_hist.size() - 3] : 1'b0;
`else
        smp = iv;
`endif
        tk = m_valid && en;
        if (smp) m_pend = 1;
        else if (tk && sel == 3'd4) m_pend = 0;
        if (tk) begin
            m_pc = model_next(m_pc, sel, l, j);
            m_valid = 0;
            m_req = 1;
        end else if (m_req && ack) begin
            m_instr = rd;
            m_req = 0;
            m_valid = 1;
        end else if (m_idle) begin
            m_idle = 0;
            m_req = 1;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 16'h0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic fetch(input int delay, input logic [31:0] rd);
        int guard = 0;
        while (!m_req && guard < 8) begin
            idle(1);
            guard++;
        end
        if (!m_req) check("fetch_timeout", 32'd0, 32'd1);
        for (int i = 0; i < delay; i++)
            cycle(1, 3'd0, 16'h0, 32'h0, 0, 32'h0, 0);
        cycle(0, 3'd0, 16'h0, 32'h0, 1, rd, 0);
    endtask

    task automatic retire(input logic [2:0] sel, input logic [15:0] l,
                          input logic [31:0] j);
        if (!m_valid) check("retire_not_valid", 32'd0, 32'd1);
        cycle(1, sel, l, j, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("req_async", 32'(imem.req), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        pcsel = 3'd0; lit = 16'h0; jt = 32'h0; pc_en = 0; irq_in = 0;
        imem.ack = 0; imem.rdata = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        fetch(0, 32'hC000_0000);
        check("t1_instr", instr, 32'hC000_0000);

        retire(3'd2, 16'h0, 32'h0000_0100);
        fetch(0, 32'h1111_0001);
        retire(3'd1, 16'hFFFE, 32'h0);
        check("t2_br", pc, 32'h0000_00FC);
        fetch(1, 32'h1111_0002);
        retire(3'd2, 16'h0, 32'h0000_0100);
        fetch(0, 32'h1111_0003);
        retire(3'd0, 16'h0, 32'h0);
        check("t2_pc4", pc, 32'h0000_0104);

        fetch(0, 32'h2222_0001);
        retire(3'd4, 16'h0, 32'h0);
        fetch(0, 32'h2222_0002);
        retire(3'd2, 16'h0, 32'h0000_0203);
        check("t3_jt_sup", pc, 32'h0000_0200);
        fetch(0, 32'h2222_0003);
        retire(3'd2, 16'h0, 32'h8000_0010);
        check("t3_jt_usr", pc, 32'h0000_0010);

        fetch(0, 32'h3333_0001);
        cycle(0, 3'd0, 16'h0, 32'h0, 0, 32'h0, 1);
        idle(4);
        check("t4_irq_hi", 32'(irq), 32'd1);
        retire(3'd4, 16'h0, 32'h0);
        check("t4_xadr", pc, XV);
        fetch(0, 32'h3333_0002);
        cycle(0, 3'd0, 16'h0, 32'h0, 0, 32'h0, 1);
        idle(4);
        check("t4_irq_sup", 32'(irq), 32'd0);
        retire(3'd4, 16'h0, 32'h0);

        fetch(5, 32'h4444_0001);

        retire(3'd0, 16'h0, 32'h0);
        check("t6_in_req", 32'(imem.req), 32'd1);
        do_reset();
        cycle(0, 3'd0, 16'h0, 32'h0, 1, 32'hDEAD_BEEF, 0);
        check("t6_late_ack", instr, 32'h0);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  16'($urandom), $urandom, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
